// File: rtl/bus_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and reset constants for bus_timer.
package bus_timer_pkg;

  localparam logic [2:0] REG_CNT_LO = 3'd0;
  localparam logic [2:0] REG_CNT_HI = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_CMP_LO = 3'd4;
  localparam logic [2:0] REG_CMP_HI = 3'd5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IE      = 2;
  localparam int STAT_IF      = 0;
  localparam int STAT_RUN     = 7;

  localparam logic [7:0]  RST_SNAP = 8'h00;
  localparam logic [7:0]  RST_DOUT = 8'h00;
  localparam logic [15:0] RST_CMP  = 16'h0000;

  // Field order puts EN at bit 0 so a CTRL write is a straight cast of din[2:0].
  typedef struct packed {
    logic ie;
    logic oneshot;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/bus_timer_if.sv
// CPU-side bus bundle for bus_timer: master is the CPU/SoC, slave is the timer.
interface bus_timer_if;
  logic       cs;
  logic       we;
  logic [2:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;
  logic       pwm;

  modport master (output cs, we, rs, din, input dout, irq, pwm);
  modport slave  (input cs, we, rs, din, output dout, irq, pwm);
endinterface

// File: rtl/bus_timer_prescaler.sv
// timer_prescaler: counts 0..PRESCALE-1 while enabled, ticks on the last count,
// holds while disabled; clr forces the count back to 0.
module timer_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0]   LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bus_timer.sv
// bus_timer: 16-bit memory-mapped interval timer with level IRQ.
// Optional compare/PWM output is built only when TIMER_PWM_EN is defined.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int          PRESCALE    = 16,
  parameter logic [15:0] RESET_LATCH = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  bus_timer_if.slave  bus
);

  logic [15:0] latch_q, latch_d;
  logic [15:0] cnt_q, cnt_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        if_q, if_d;
  logic [7:0]  hi_snap_q, hi_snap_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  cmp_lo_rd, cmp_hi_rd;

  logic wr, rd_lo;
  logic wr_latch_lo, wr_latch_hi, wr_ctrl, wr_status;
  logic tick, term;

  assign wr          = bus.cs & bus.we;
  assign rd_lo       = bus.cs & ~bus.we & (bus.rs == REG_CNT_LO);
  assign wr_latch_lo = wr & (bus.rs == REG_CNT_LO);
  assign wr_latch_hi = wr & (bus.rs == REG_CNT_HI);
  assign wr_ctrl     = wr & (bus.rs == REG_CTRL);
  assign wr_status   = wr & (bus.rs == REG_STATUS);

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_q.en),
    .clr  (wr_latch_hi),
    .tick (tick)
  );

  // A full reload in the same cycle swallows the terminal event entirely.
  assign term = tick & (cnt_q == 16'h0000) & ~wr_latch_hi;

  always_comb begin
    latch_d   = latch_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    if_d      = if_q;
    hi_snap_d = hi_snap_q;

    if (wr_latch_lo) latch_d[7:0] = bus.din;

    if (tick) cnt_d = (cnt_q == 16'h0000) ? latch_q : cnt_q - 16'd1;

    // Clear first so a coincident terminal event leaves IF set.
    if (wr_status && bus.din[STAT_IF]) if_d = 1'b0;
    if (term) begin
      if_d = 1'b1;
      if (ctrl_q.oneshot) ctrl_d.en = 1'b0;
    end

    if (wr_ctrl) ctrl_d = ctrl_t'(bus.din[2:0]);

    if (wr_latch_hi) begin
      latch_d[15:8] = bus.din;
      cnt_d         = {bus.din, latch_q[7:0]};
      if_d          = 1'b0;
    end

    // Snapshot the high byte on a low-byte read so LO-then-HI is atomic.
    if (rd_lo) hi_snap_d = cnt_q[15:8];
  end

  always_comb begin
    dout_d = 8'h00;
    case (bus.rs)
      REG_CNT_LO: dout_d = cnt_q[7:0];
      REG_CNT_HI: dout_d = hi_snap_q;
      REG_CTRL:   dout_d = {5'b00000, ctrl_q};
      REG_STATUS: dout_d = {ctrl_q.en, 6'b000000, if_q};
      REG_CMP_LO: dout_d = cmp_lo_rd;
      REG_CMP_HI: dout_d = cmp_hi_rd;
      default:    dout_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q   <= RESET_LATCH;
      cnt_q     <= RESET_LATCH;
      ctrl_q    <= '0;
      if_q      <= 1'b0;
      hi_snap_q <= RST_SNAP;
      dout_q    <= RST_DOUT;
    end else begin
      latch_q   <= latch_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      if_q      <= if_d;
      hi_snap_q <= hi_snap_d;
      dout_q    <= dout_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.irq  = if_q & ctrl_q.ie;

`ifdef TIMER_PWM_EN
  logic [15:0] cmp_q, cmp_d;
  logic        pwm_q, pwm_d;

  always_comb begin
    cmp_d = cmp_q;
    if (wr && bus.rs == REG_CMP_LO) cmp_d[7:0]  = bus.din;
    if (wr && bus.rs == REG_CMP_HI) cmp_d[15:8] = bus.din;
    pwm_d = ctrl_q.en & (cnt_q < cmp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q <= RST_CMP;
      pwm_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      pwm_q <= pwm_d;
    end
  end

  assign cmp_lo_rd = cmp_q[7:0];
  assign cmp_hi_rd = cmp_q[15:8];
  assign bus.pwm   = pwm_q;
`else
  assign cmp_lo_rd = 8'h00;
  assign cmp_hi_rd = 8'h00;
  assign bus.pwm   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_timer.sv
// Randomised scoreboard bench for bus_timer against a cycle-level behavioural model.
module tb_bus_timer;
  import bus_timer_pkg::*;

  localparam int          PRESCALE    = 4;
  localparam logic [15:0] RESET_LATCH = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_timer_if bus();

  bus_timer #(.PRESCALE(PRESCALE), .RESET_LATCH(RESET_LATCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dout;
    logic       irq;
    logic       pwm;
    string      tag;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "reset";

  // Reference model state
  logic [15:0] m_latch, m_cnt, m_cmp;
  logic [7:0]  m_snap;
  bit          m_en, m_os, m_ie, m_if, m_pwm;
  int          m_pre;

  task automatic model_reset();
    m_latch = RESET_LATCH;
    m_cnt   = RESET_LATCH;
    m_cmp   = 16'h0000;
    m_snap  = 8'h00;
    m_en = 0; m_os = 0; m_ie = 0; m_if = 0; m_pwm = 0;
    m_pre = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] r);
    case (r)
      3'd0: return m_cnt[7:0];
      3'd1: return m_snap;
      3'd2: return {5'b00000, m_ie, m_os, m_en};
      3'd3: return {m_en, 6'b000000, m_if};
`ifdef TIMER_PWM_EN
      3'd4: return m_cmp[7:0];
      3'd5: return m_cmp[15:8];
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input bit c, input bit w, input logic [2:0] r, input logic [7:0] d);
    bit wr, tick, term;
    wr = c & w;
`ifdef TIMER_PWM_EN
    m_pwm = m_en && (m_cnt < m_cmp);
`else
    m_pwm = 0;
`endif
    if (c && !w && r == 3'd0) m_snap = m_cnt[15:8];
    tick = 0;
    if (m_en) begin
      m_pre = m_pre + 1;
      if (m_pre == PRESCALE) begin
        m_pre = 0;
        tick  = 1;
      end
    end
    term = tick && (m_cnt == 16'h0000);
    if (wr && r == 3'd1) begin
      m_latch[15:8] = d;
      m_cnt         = {d, m_latch[7:0]};
      m_pre         = 0;
      m_if          = 0;
    end else begin
      if (tick) m_cnt = term ? m_latch : 16'(m_cnt - 16'd1);
      if (wr && r == 3'd3 && d[0]) m_if = 0;
      if (term) begin
        m_if = 1;
        if (m_os) m_en = 0;
      end
    end
    if (wr && r == 3'd0) m_latch[7:0] = d;
    if (wr && r == 3'd2) {m_ie, m_os, m_en} = d[2:0];
`ifdef TIMER_PWM_EN
    if (wr && r == 3'd4) m_cmp[7:0]  = d;
    if (wr && r == 3'd5) m_cmp[15:8] = d;
`endif
  endtask

  function automatic bit term_next();
    return m_en && (m_pre == PRESCALE - 1) && (m_cnt == 16'h0000);
  endfunction

  // One bus cycle: drive, predict, let the edge happen, queue the expectation.
  task automatic cyc(input bit c, input bit w, input logic [2:0] r, input logic [7:0] d,
                     input bit do_rst = 1'b0);
    exp_t e;
    bus.cs = c; bus.we = w; bus.rs = r; bus.din = d; rst = do_rst;
    e.dout = do_rst ? 8'h00 : model_read(r);
    @(posedge clk);
    if (do_rst) model_reset();
    else        model_step(c, w, r, d);
    e.irq = m_if & m_ie;
    e.pwm = m_pwm;
    e.tag = cur_tag;
    sb.push_back(e);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] r, input logic [7:0] d);
    cyc(1'b1, 1'b1, r, d);
  endtask

  task automatic rd_reg(input logic [2:0] r);
    cyc(1'b1, 1'b0, r, 8'h00);
  endtask

  task automatic wait_term(input string nm);
    int k;
    k = 0;
    while (!term_next() && k < 2000) begin
      rd_reg(3'd3);
      k++;
    end
    if (!term_next()) begin
      checks++;
      errors++;
      $display("FAIL %s terminal not reached within %0d cycles", nm, k);
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %02h want %02h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.tag, ".dout"}, bus.dout, mon_e.dout);
      chk({mon_e.tag, ".irq"}, {7'b0, bus.irq}, {7'b0, mon_e.irq});
      chk({mon_e.tag, ".pwm"}, {7'b0, bus.pwm}, {7'b0, mon_e.pwm});
    end
  end

  initial begin
    logic [2:0] r;
    logic [7:0] d;
    bit         c, w;
    int         k;

    model_reset();
    bus.cs = 0; bus.we = 0; bus.rs = 0; bus.din = 0;
    repeat (3) cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);

    cur_tag = "reset_rd";
    for (int i = 0; i < 8; i++) rd_reg(3'(i));

    cur_tag = "continuous";
    wr_reg(3'd0, 8'h03); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h05);
    repeat (40) rd_reg(3'd3);
    wr_reg(3'd3, 8'h01);
    repeat (24) rd_reg(3'd3);

    cur_tag = "oneshot";
    wr_reg(3'd2, 8'h00);
    wr_reg(3'd0, 8'h02); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h07);
    repeat (20) rd_reg(3'd3);
    rd_reg(3'd0); rd_reg(3'd1); rd_reg(3'd2);

    cur_tag = "atomic";
    wr_reg(3'd2, 8'h00);
    wr_reg(3'd0, 8'h00); wr_reg(3'd1, 8'h01); wr_reg(3'd2, 8'h01);
    k = 0;
    while (!(m_en && m_pre == PRESCALE - 1) && k < 16) begin
      cyc(1'b0, 1'b0, 3'd7, 8'h00);
      k++;
    end
    rd_reg(3'd0); rd_reg(3'd1); rd_reg(3'd0); rd_reg(3'd1);

    cur_tag = "clr_vs_term";
    wr_reg(3'd2, 8'h00);
    wr_reg(3'd0, 8'h01); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h05);
    wait_term(cur_tag);
    wr_reg(3'd3, 8'h01);
    rd_reg(3'd3);

    cur_tag = "lhi_vs_term";
    wait_term(cur_tag);
    wr_reg(3'd1, 8'h00);
    rd_reg(3'd3); rd_reg(3'd0); rd_reg(3'd1);

    cur_tag = "ie_off";
    wait_term(cur_tag);
    rd_reg(3'd3);
    wr_reg(3'd2, 8'h01);
    rd_reg(3'd3);

    cur_tag = "cmp";
    wr_reg(3'd4, 8'h04); wr_reg(3'd5, 8'h00);
    rd_reg(3'd4); rd_reg(3'd5);
    wr_reg(3'd2, 8'h00);
    wr_reg(3'd0, 8'h09); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h01);
    repeat (60) rd_reg(3'd0);

    cur_tag = "random";
    for (int i = 0; i < 1500; i++) begin
      r = 3'($urandom_range(0, 7));
      c = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      if (w && r == 3'd1) d = 8'($urandom_range(0, 1));
      if (w && r == 3'd0) d = 8'($urandom_range(0, 8));
      cyc(c, w, r, d);
      if (i == 700) begin
        cur_tag = "mid_reset";
        repeat (2) cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        rd_reg(3'd3); rd_reg(3'd0); rd_reg(3'd1);
        cur_tag = "random";
      end
    end

    repeat (2) cyc(1'b0, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
